// File: rtl/link_control.sv
// link_control: game-step sequencer for the Link character datapath.
//
// Walks init -> map redraw -> sprite draw -> idle -> latch input -> collision
// wait -> apply move -> redraw, once every MOVE_DIV frame ticks. The state
// strobes are registered Moore decodes of the next state, so each strobe is
// high in exactly the cycles the FSM spends in its state. The raw buttons are
// priority-encoded into a 3-bit action code when the step is latched.
//
// Optional feature macro: CTRL_WATCHDOG_EN
//   defined   : a cycle counter bounds the time spent in map/sprite draw; on
//               expiry wdog_err is set (sticky) and the FSM falls back to idle.
//   undefined : draw states wait indefinitely; wdog_err is tied low.
//
// Ports
//   clock         in   system clock
//   resetn        in   asynchronous active-low reset
//   frame_tick    in   one-cycle pulse per video frame
//   keys[4:0]     in   {attack, up, down, left, right}, active high
//   collision[1:0]in   non-zero: the requested move is blocked
//   map_done      in   map redraw complete pulse
//   draw_done     in   sprite draw complete
//   init          out  one-cycle strobe after reset / recovery
//   idle          out  waiting for the next game step
//   reg_action    out  action latched this cycle
//   apply_action  out  link_char applies the action this cycle
//   draw_map      out  map redraw in progress
//   draw_char     out  sprite draw in progress
//   user_input    out  000 none, 001 attack, 010 up, 011 down, 100 left, 101 right
//   frame_overrun out  sticky: a frame tick arrived outside idle
//   wdog_err      out  sticky: draw watchdog expired
module link_control #(
    parameter int unsigned MOVE_DIV    = 2,
    parameter int unsigned WDOG_CYCLES = 65535
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic [4:0] keys,
    input  logic [1:0] collision,
    input  logic       map_done,
    input  logic       draw_done,
    output logic       init,
    output logic       idle,
    output logic       reg_action,
    output logic       apply_action,
    output logic       draw_map,
    output logic       draw_char,
    output logic [2:0] user_input,
    output logic       frame_overrun,
    output logic       wdog_err
);

    localparam int unsigned FCW = $clog2(MOVE_DIV) + 1;
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(MOVE_DIV - 1);

    typedef enum logic [2:0] {
        StInit  = 3'd0,
        StMap   = 3'd1,
        StChar  = 3'd2,
        StIdle  = 3'd3,
        StReg   = 3'd4,
        StColl  = 3'd5,
        StApply = 3'd6
    } state_e;

    state_e         state_q, state_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [2:0]     user_input_q, user_input_d;
    logic           overrun_q, overrun_d;
    logic           init_q, idle_q, reg_q, apply_q, map_q, char_q;
    logic           wdog_trip;

    // Highest-priority pressed key wins: attack > up > down > left > right.
    function automatic logic [2:0] encode_keys(input logic [4:0] k);
        logic [2:0] code;
        code = 3'b000;
        if (k[4])      code = 3'b001;
        else if (k[3]) code = 3'b010;
        else if (k[2]) code = 3'b011;
        else if (k[1]) code = 3'b100;
        else if (k[0]) code = 3'b101;
        return code;
    endfunction

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        user_input_d = user_input_q;
        // Ticks outside idle are dropped from the step count and flagged.
        overrun_d    = overrun_q | (frame_tick && (state_q != StIdle));

        case (state_q)
            // Reset leaves init_q low, so the FSM lingers here one extra cycle
            // to give the init strobe its single high cycle.
            StInit: begin
                if (init_q) state_d = StMap;
            end
            StMap: begin
                if (map_done)       state_d = StChar;
                else if (wdog_trip) state_d = StIdle;
            end
            StChar: begin
                if (draw_done)      state_d = StIdle;
                else if (wdog_trip) state_d = StIdle;
            end
            StIdle: begin
                if (frame_tick) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = StReg;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FCW'(1);
                    end
                end
            end
            StReg: begin
                user_input_d = encode_keys(keys);
                state_d      = StColl;
            end
            StColl: begin
                // Blocked moves are cancelled; attack and none pass through.
                if ((collision != 2'b00) && (user_input_q >= 3'b010) &&
                    (user_input_q <= 3'b101)) begin
                    user_input_d = 3'b000;
                end
                state_d = StApply;
            end
            StApply: begin
                state_d = StMap;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StInit;
            frame_cnt_q  <= '0;
            user_input_q <= 3'b000;
            overrun_q    <= 1'b0;
            init_q       <= 1'b0;
            idle_q       <= 1'b0;
            reg_q        <= 1'b0;
            apply_q      <= 1'b0;
            map_q        <= 1'b0;
            char_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            user_input_q <= user_input_d;
            overrun_q    <= overrun_d;
            init_q       <= (state_d == StInit);
            idle_q       <= (state_d == StIdle);
            reg_q        <= (state_d == StReg);
            apply_q      <= (state_d == StApply);
            map_q        <= (state_d == StMap);
            char_q       <= (state_d == StChar);
        end
    end

`ifdef CTRL_WATCHDOG_EN
    localparam int unsigned WCW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WCW-1:0] WDOG_LAST = WCW'(WDOG_CYCLES - 1);

    logic [WCW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic           wdog_err_q;
    logic           in_draw;

    assign in_draw = (state_q == StMap) || (state_q == StChar);

    // Counter holds the number of cycles already spent in the current draw
    // state; it restarts from zero on every state change.
    assign wdog_cnt_d = (in_draw && (state_d == state_q)) ? wdog_cnt_q + WCW'(1) : '0;

    assign wdog_trip = in_draw && (wdog_cnt_q == WDOG_LAST) &&
                       !((state_q == StMap) ? map_done : draw_done);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_q | wdog_trip;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    assign wdog_trip = 1'b0;
    // WDOG_CYCLES has no effect in this build; referenced only to keep it live.
    assign wdog_err  = 1'b0 && (WDOG_CYCLES != 0);
`endif

    assign init          = init_q;
    assign idle          = idle_q;
    assign reg_action    = reg_q;
    assign apply_action  = apply_q;
    assign draw_map      = map_q;
    assign draw_char     = char_q;
    assign user_input    = user_input_q;
    assign frame_overrun = overrun_q;

endmodule
